dribble_sched: RTL

- Sequences the dribbler magnitude/direction datapath.
- Arbitrates between a host (RF packet) speed command and an infrared-triggered auto-dribble level.
- Slew-limits the selected target once per update tick, and inserts a zero-output dead time before any direction reversal.
- Drives the datapath's signed command input and its enable strobe.

---
 rtl/dribble_pkg.sv | 9 +
 rtl/dribble_slew.sv | 17 +
 rtl/dribble_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/dribble_pkg.sv
// dribble_pkg: shared types, limits and the clamp helper for the dribbler sequencer.
package dribble_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, BRAKE} state_t;
  typedef logic signed [31:0] cmd_t;
  localparam cmd_t MAX_CMD_DEF = 32'sd3072000;
  function automatic cmd_t clamp_cmd(input cmd_t v, input cmd_t lim);
    return v > lim ? lim : (v < -lim ? -lim : v);
  endfunction
endpackage

// File: rtl/dribble_slew.sv
// dribble_slew: combinational step limiter moving cur toward tgt by at most STEP without overshoot.
module dribble_slew
  import dribble_pkg::*;
#(
  parameter logic signed [31:0] STEP = 32'sd32768
) (
  input  logic signed [31:0] cur,
  input  logic signed [31:0] tgt,
  output logic signed [31:0] nxt
);
  localparam logic signed [32:0] S = 33'(STEP);
  logic signed [32:0] diff;
  always_comb begin
    diff = {tgt[31], tgt} - {cur[31], cur};
    nxt = diff > S ? cur + STEP : (diff < -S ? cur - STEP : tgt);
  end
endmodule

// File: rtl/dribble_sched.sv
// dribble_sched: host/auto target arbitration, per-tick slew limiting and reversal dead time.
// Optional host watchdog enabled by defining DRIBBLE_WDOG_EN.
module dribble_sched
  import dribble_pkg::*;
#(
  parameter logic signed [31:0] STEP = 32'sd32768,
  parameter logic signed [31:0] MAX_CMD = MAX_CMD_DEF,
  parameter int DEAD_TICKS = 4,
  parameter int WDOG_TICKS = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic signed [31:0] host_cmd,
  input  logic               auto_en,
  input  logic               infrain,
  input  logic signed [31:0] auto_level,
  output logic signed [31:0] dp_data,
  output logic               dp_enable,
  output logic               busy
);
  state_t state_q, state_d;
  cmd_t cur_q, cur_d, tgt_q, tgt_d, host_q, host_d;
  cmd_t host_sel, tgt, to_tgt, to_zero;
  logic [7:0] dead_q, dead_d;
  logic dir_q, dir_d, en_q, en_d, hs, rev;
`ifdef DRIBBLE_WDOG_EN
  logic [15:0] wd_q, wd_d;
`endif
  dribble_slew #(.STEP(STEP)) u_to_tgt (.cur(cur_q), .tgt(tgt), .nxt(to_tgt));
  dribble_slew #(.STEP(STEP)) u_to_zero (.cur(cur_q), .tgt('0), .nxt(to_zero));
  assign host_ready = state_q != BRAKE;
  assign dp_data = cur_q;
  assign dp_enable = en_q;
  assign busy = (state_q == RAMP && cur_q != tgt_q) || state_q == BRAKE;
  always_comb begin
    hs = host_valid && host_ready;
    host_sel = hs ? clamp_cmd(host_cmd, MAX_CMD) : host_q;
    host_d = host_sel;
`ifdef DRIBBLE_WDOG_EN
    wd_d = hs ? '0 : (tick && wd_q != 16'(WDOG_TICKS)) ? wd_q + 16'd1 : wd_q;
    host_d = (!hs && wd_d == 16'(WDOG_TICKS)) ? '0 : host_sel;
`endif
    tgt = host_sel != 0 ? host_sel : (auto_en && !infrain) ? clamp_cmd(auto_level, MAX_CMD) : '0;
    rev = tgt != 0 && cur_q != 0 && tgt[31] != cur_q[31];
    en_d = tick;
    state_d = state_q;
    cur_d = cur_q;
    tgt_d = tgt_q;
    dead_d = dead_q;
    dir_d = dir_q;
    if (tick) begin
      tgt_d = tgt;
      if (state_q == BRAKE) begin
        cur_d = '0;
        // a further flip of the target restarts the dead time toward the new direction
        if (tgt != 0 && tgt[31] != dir_q) begin
          dead_d = 8'(DEAD_TICKS);
          dir_d = tgt[31];
        end else begin
          dead_d = dead_q <= 8'd1 ? 8'd0 : dead_q - 8'd1;
          state_d = dead_q <= 8'd1 ? RAMP : BRAKE;
        end
      end else if (rev) begin
        cur_d = to_zero;
        state_d = to_zero == 0 ? BRAKE : RAMP;
        dead_d = to_zero == 0 ? 8'(DEAD_TICKS) : dead_q;
        dir_d = tgt[31];
      end else begin
        cur_d = to_tgt;
        state_d = (to_tgt == 0 && tgt == 0) ? IDLE : RAMP;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q <= '0;
      tgt_q <= '0;
      host_q <= '0;
      dead_q <= '0;
      dir_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      host_q <= host_d;
      dead_q <= dead_d;
      dir_q <= dir_d;
      en_q <= en_d;
    end
  end
`ifdef DRIBBLE_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else wd_q <= wd_d;
  end
`endif
endmodule
